// File: rtl/saturn_nibble_decoder.sv
// Saturn instruction decoder: collects the fetched nibble stream, resolves
// each instruction's length from its leading nibbles and presents complete
// instructions to the execute stage over a valid/ready handshake.
module saturn_nibble_decoder #(
  parameter int MAX_NIBBLES = 21,
  parameter int LEN_W       = 5
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [3:0]               i_phases,
  input  logic                     i_debug_cycle,
  input  logic                     i_bus_busy,
  input  logic [3:0]               i_nibble,
  input  logic                     i_flush,
  input  logic                     i_ins_ready,
  output logic                     o_ins_valid,
  output logic [4*MAX_NIBBLES-1:0] o_ins_nibbles,
  output logic [LEN_W-1:0]         o_ins_len,
  output logic [3:0]               o_ins_class,
  output logic                     o_stall,
  output logic                     o_error
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [4*MAX_NIBBLES-1:0] buf_q, buf_d;
  logic [LEN_W-1:0]         cnt_q, cnt_d;
  // Zero means "not yet resolved"; every real length is at least 2.
  logic [LEN_W-1:0]         len_q, len_d;
  logic [3:0]               class_q, class_d;
  logic                     stall_q, stall_d;
  logic                     err_q, err_d;

  logic                     acc;
  logic                     needs_n1;
  logic [5:0]               len0;
  logic [5:0]               len1;
  logic [LEN_W-1:0]         cur_len;
  logic                     unused_phases;

  // Instruction length from the first two nibbles (n1 ignored unless 3x/8x).
  function automatic logic [5:0] decode_len(input logic [3:0] n0, input logic [3:0] n1);
    logic [5:0] l;
    case (n0)
      4'h0, 4'h2: l = 6'd2;
      4'h3:       l = 6'd3 + {2'b00, n1};
      4'h6, 4'h7: l = 6'd4;
      4'h8: begin
        case (n1)
          4'hC, 4'hE: l = 6'd6;
          4'hD, 4'hF: l = 6'd7;
          default:    l = 6'd3;
        endcase
      end
      4'h9:       l = 6'd5;
      default:    l = 6'd3;
    endcase
    return l;
  endfunction

  assign unused_phases = ^{i_phases[3], i_phases[1:0]};

  assign acc = i_phases[2] & ~i_debug_cycle & ~i_bus_busy & (state_q != DONE) & ~i_flush;

  assign needs_n1 = (i_nibble == 4'h3) || (i_nibble == 4'h8);
  assign len0     = decode_len(i_nibble, 4'h0);
  assign len1     = decode_len(buf_q[3:0], i_nibble);
  assign cur_len  = (len_q == '0) ? LEN_W'(len1) : len_q;

  // Next-state and datapath update: flush first, then per-state behaviour.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    class_d = class_q;
    err_d   = 1'b0;

    if (i_flush) begin
      state_d = IDLE;
      buf_d   = '0;
      cnt_d   = '0;
      len_d   = '0;
      class_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (acc) begin
            buf_d      = '0;
            buf_d[3:0] = i_nibble;
            cnt_d      = LEN_W'(1);
            class_d    = i_nibble;
            state_d    = COLLECT;
            if (!needs_n1) begin
              if (int'(len0) > MAX_NIBBLES) begin
                err_d   = 1'b1;
                state_d = IDLE;
                buf_d   = '0;
                cnt_d   = '0;
                class_d = '0;
              end else begin
                len_d = LEN_W'(len0);
              end
            end
          end
        end
        COLLECT: begin
          if (acc) begin
            if ((len_q == '0) && (int'(len1) > MAX_NIBBLES)) begin
              err_d   = 1'b1;
              state_d = IDLE;
              buf_d   = '0;
              cnt_d   = '0;
              len_d   = '0;
              class_d = '0;
            end else begin
              for (int unsigned k = 0; k < MAX_NIBBLES; k++) begin
                if (cnt_q == LEN_W'(k)) buf_d[4*k +: 4] = i_nibble;
              end
              cnt_d = cnt_q + LEN_W'(1);
              len_d = cur_len;
              if (cnt_q + LEN_W'(1) == cur_len) state_d = DONE;
            end
          end
        end
        DONE: begin
          if (i_ins_ready) begin
            state_d = IDLE;
            buf_d   = '0;
            cnt_d   = '0;
            len_d   = '0;
            class_d = '0;
          end
        end
        default: begin
          state_d = IDLE;
          buf_d   = '0;
          cnt_d   = '0;
          len_d   = '0;
          class_d = '0;
        end
      endcase
    end

    stall_d = (state_d == DONE);
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      class_q <= '0;
      stall_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      class_q <= class_d;
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign o_ins_valid   = (state_q == DONE);
  assign o_ins_nibbles = buf_q;
  assign o_ins_len     = len_q;
  assign o_ins_class   = class_q;
  assign o_stall       = stall_q;
  assign o_error       = err_q;

endmodule

// File: tb/tb_saturn_nibble_decoder.sv
// Directed and randomized bench for saturn_nibble_decoder (default and
// MAX_NIBBLES=7 instances driven from the same inputs).
module tb_saturn_nibble_decoder;

  localparam int MAXN = 21;
  localparam int LW   = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] phases;
  logic       dbg, busy, flush, ready;
  logic [3:0] nib;

  logic            a_valid, a_stall, a_err;
  logic [4*MAXN-1:0] a_nibs;
  logic [LW-1:0]   a_len;
  logic [3:0]      a_class;

  logic            b_valid, b_stall, b_err;
  logic [27:0]     b_nibs;
  logic [2:0]      b_len;
  logic [3:0]      b_class;

  int total = 0;
  int bad   = 0;

  int unsigned base_len [16] = '{2, 3, 2, 0, 3, 3, 4, 4, 0, 5, 3, 3, 3, 3, 3, 3};

  saturn_nibble_decoder #(.MAX_NIBBLES(MAXN), .LEN_W(LW)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_phases(phases), .i_debug_cycle(dbg),
    .i_bus_busy(busy), .i_nibble(nib), .i_flush(flush), .i_ins_ready(ready),
    .o_ins_valid(a_valid), .o_ins_nibbles(a_nibs), .o_ins_len(a_len),
    .o_ins_class(a_class), .o_stall(a_stall), .o_error(a_err)
  );

  saturn_nibble_decoder #(.MAX_NIBBLES(7), .LEN_W(3)) dut7 (
    .i_clk(clk), .i_reset(rst_n), .i_phases(phases), .i_debug_cycle(dbg),
    .i_bus_busy(busy), .i_nibble(nib), .i_flush(flush), .i_ins_ready(ready),
    .o_ins_valid(b_valid), .o_ins_nibbles(b_nibs), .o_ins_len(b_len),
    .o_ins_class(b_class), .o_stall(b_stall), .o_error(b_err)
  );

  function automatic int unsigned ref_len(input int unsigned n0, input int unsigned n1);
    if (n0 == 3) return 3 + n1;
    if (n0 == 8) return (n1 >= 12) ? 6 + (n1 % 2) : 3;
    return base_len[n0];
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [3:0] n);
    phases = 4'b0100;
    nib    = n;
    tick();
    phases = 4'b0001;
    nib    = 4'h0;
  endtask

  task automatic handshake();
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  initial begin
    logic [4*MAXN-1:0] expv;
    logic [3:0]        nb [MAXN];
    int unsigned       L;

    rst_n = 1'b0; phases = 4'b0001; dbg = 1'b0; busy = 1'b0;
    flush = 1'b0; ready = 1'b0; nib = 4'h0;
    #12;
    check("rst_valid", a_valid, 0);
    check("rst_stall", a_stall, 0);
    check("rst_nibs",  a_nibs, 0);
    check("rst_len",   a_len, 0);
    check("rst_err",   a_err, 0);
    rst_n = 1'b1;
    tick();

    // Asynchronous reset mid-instruction
    offer(4'h3);
    offer(4'h2);
    check("pre_rst_nibs", a_nibs, 84'h23);
    rst_n = 1'b0;
    #1;
    check("arst_valid", a_valid, 0);
    check("arst_stall", a_stall, 0);
    check("arst_nibs",  a_nibs, 0);
    tick();
    rst_n = 1'b1;
    offer(4'h2);
    check("r2_notyet", a_valid, 0);
    offer(4'h5);
    check("r2_valid", a_valid, 1);
    check("r2_len",   a_len, 2);
    check("r2_nibs",  a_nibs, 84'h52);
    check("r2_class", a_class, 2);
    check("r2_stall", a_stall, 1);
    handshake();
    check("r2_taken", a_valid, 0);
    check("r2_len0",  a_len, 0);

    // Variable-length 3n instruction with ready already high
    ready = 1'b1;
    offer(4'h3); offer(4'h2); offer(4'hA); offer(4'hB);
    check("lc_notyet", a_valid, 0);
    offer(4'hC);
    check("lc_valid", a_valid, 1);
    check("lc_nibs",  a_nibs, 84'hCBA23);
    check("lc_len",   a_len, 5);
    check("lc_class", a_class, 3);
    tick();
    ready = 1'b0;
    check("lc_idle", a_valid, 0);
    check("lc_idle_stall", a_stall, 0);

    // Backpressure: nibbles offered while DONE are ignored
    offer(4'h6); offer(4'h1); offer(4'h2); offer(4'h3);
    check("bp_valid", a_valid, 1);
    check("bp_len",   a_len, 4);
    for (int i = 0; i < 10; i++) offer(4'hF);
    check("bp_stall", a_stall, 1);
    check("bp_nibs",  a_nibs, 84'h3216);
    check("bp_len2",  a_len, 4);
    ready = 1'b1;
    offer(4'hF);
    ready = 1'b0;
    check("bp_taken", a_valid, 0);
    tick();
    check("bp_idle_len", a_len, 0);
    offer(4'h2); offer(4'h7);
    check("bp_next_nibs", a_nibs, 84'h72);
    check("bp_next_len",  a_len, 2);
    handshake();

    // Bus busy / debug cycle skip decode phases
    offer(4'h8); offer(4'hF); offer(4'h1);
    busy = 1'b1; offer(4'h9); offer(4'h9); busy = 1'b0;
    dbg  = 1'b1; offer(4'h9); dbg = 1'b0;
    offer(4'h2); offer(4'h3); offer(4'h4);
    check("st_notyet", a_valid, 0);
    offer(4'h5);
    check("st_valid", a_valid, 1);
    check("st_len",   a_len, 7);
    check("st_nibs",  a_nibs, 84'h54321F8);
    check("st_class", a_class, 8);
    handshake();

    // Overflow on the MAX_NIBBLES=7 instance
    rst_n = 1'b0; #1; tick(); rst_n = 1'b1;
    offer(4'h3);
    check("ov_noerr_yet", b_err, 0);
    offer(4'hF);
    check("ov_err",    b_err, 1);
    check("ov_valid",  b_valid, 0);
    check("ov_a_err",  a_err, 0);
    tick();
    check("ov_err_off", b_err, 0);
    check("ov_nibs",    b_nibs, 0);
    check("ov_len",     b_len, 0);
    offer(4'h2); offer(4'h1);
    check("ov_recover", b_nibs, 28'h12);
    check("ov_rec_val", b_valid, 1);
    flush = 1'b1; tick(); flush = 1'b0;
    check("ov_flush_b", b_valid, 0);
    check("ov_flush_a", a_valid, 0);

    // Flush mid-collect, with a decode phase on the same edge
    offer(4'h8); offer(4'hC); offer(4'h1);
    flush = 1'b1; offer(4'h5); flush = 1'b0;
    check("fl_valid", a_valid, 0);
    check("fl_nibs",  a_nibs, 0);
    check("fl_len",   a_len, 0);
    check("fl_err",   a_err, 0);
    offer(4'h0); offer(4'h3);
    check("fl_next_valid", a_valid, 1);
    check("fl_next_nibs",  a_nibs, 84'h30);
    check("fl_next_len",   a_len, 2);
    handshake();

    // Randomized instructions against the reference length table
    for (int it = 0; it < 60; it++) begin
      for (int k = 0; k < MAXN; k++) nb[k] = 4'($urandom_range(0, 15));
      L = ref_len(nb[0], nb[1]);
      expv = '0;
      for (int k = 0; k < int'(L); k++) expv[4*k +: 4] = nb[k];
      for (int k = 0; k < int'(L); k++) begin
        repeat ($urandom_range(0, 1)) tick();
        if ($urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 1) == 0) busy = 1'b1; else dbg = 1'b1;
          offer(4'($urandom_range(0, 15)));
          busy = 1'b0; dbg = 1'b0;
        end
        offer(nb[k]);
        if (k < int'(L) - 1) check("rnd_early", a_valid, 0);
      end
      check("rnd_valid", a_valid, 1);
      check("rnd_len",   a_len, L);
      check("rnd_class", a_class, nb[0]);
      check("rnd_nibs",  a_nibs, expv);
      repeat ($urandom_range(0, 2)) begin
        offer(4'($urandom_range(0, 15)));
        check("rnd_hold", a_nibs, expv);
      end
      handshake();
      check("rnd_taken", a_valid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/saturn_nibble_decoder.md
# saturn_nibble_decoder

Parametrised successor to the Saturn instruction decoder stub. Consumes the fetched nibble stream one nibble per decode phase and determines each instruction's length from its leading nibbles. Packs the nibbles into a buffer and presents each complete instruction to the execute stage over a valid/ready handshake. It sits between the fetch/bus unit and the execute stage, and it stalls fetch while an instruction is waiting to be taken.

## Interface

Parameters:
- MAX_NIBBLES, 21, buffer depth in nibbles; legal range 7..21.
- LEN_W, 5, width of length/counter fields; must satisfy 2^LEN_W > MAX_NIBBLES.

Ports:
- i_clk  in  1  system clock; all state changes on the rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_phases  in  4  one-hot phase strobes; bit 2 = decode phase.
- i_debug_cycle  in  1  debugger owns the cycle; no nibble is accepted.
- i_bus_busy  in  1  bus transaction in progress; no nibble is accepted.
- i_nibble  in  4  fetched nibble, qualified by the accept condition.
- i_flush  in  1  abort the current or pending instruction (e.g. taken jump).
- i_ins_ready  in  1  execute stage takes the presented instruction.
- o_ins_valid  out  1  complete instruction presented.
- o_ins_nibbles  out  4*MAX_NIBBLES  nibble k is in bits [4k+3:4k]; unused nibbles read 0.
- o_ins_len  out  LEN_W  instruction length in nibbles.
- o_ins_class  out  4  first nibble (opcode class).
- o_stall  out  1  decoder is full; fetch must hold the PC.
- o_error  out  1  one-cycle pulse: decoded length exceeds MAX_NIBBLES.

## Operation

- Accept condition: `acc = i_phases[2] & !i_debug_cycle & !i_bus_busy & state != DONE & !i_flush`.
- States:
  - IDLE: waiting for nibble 0.
  - COLLECT: gathering nibbles.
  - DONE: o_ins_valid held.
- IDLE transitions:
  - On acc: store the nibble at index 0, cnt = 1, go to COLLECT.
  - First nibble 2, 4, 5, 6, 7, A–F, 0 or 1: length is fixed by nibble 0 (see table).
- Length table:
  - 0x, 2x: 2.
  - 1x, A–F: 3.
  - 4x, 5x: 3.
  - 6x, 7x: 4.
  - 9x: 5.
  - 3n: 3+n (3..18).
  - 8C, 8E: 6.
  - 8D, 8F: 7.
  - Other 8x: 3.
- Length for 3x and 8x is resolved when nibble 1 arrives. Every other length is resolved on nibble 0.
- COLLECT: each acc stores the nibble at index cnt and increments cnt. When cnt+1 equals the length, go to DONE.
- Length exceeding MAX_NIBBLES:
  - o_error pulses for one cycle.
  - Buffer is cleared and state returns to IDLE.
  - Remaining nibbles of that instruction are not skipped; fetch handles recovery.
- DONE:
  - o_ins_valid = 1, o_stall = 1.
  - Outputs stay stable until i_ins_ready = 1 at a rising edge.
  - The edge that takes the instruction clears the buffer and returns to IDLE.
  - A nibble is never accepted in DONE, even when i_ins_ready = 1 on that edge.
- i_flush (sampled at the edge):
  - Forces IDLE, clears the buffer, cnt and o_ins_valid.
  - Has priority over acc and i_ins_ready.
  - No o_error is raised.
- Reset (asynchronous, any time, including mid-instruction): state IDLE, all outputs 0, buffer 0, cnt 0.

## Timing

- One nibble per accepted decode phase. No internal latency beyond registering.
- o_ins_valid rises on the same edge that stores the last nibble.
- An N-nibble instruction is valid N accepted phases after its first nibble.
- o_stall is a registered copy of the DONE state.
- o_error is asserted at the edge that stores the length-determining nibble (nibble 1 for 3x). It deasserts on the next edge.
- i_bus_busy or i_debug_cycle high during phase 2 means that phase is skipped. cnt is unchanged and no data is lost.
- o_ins_len and o_ins_class are valid whenever o_ins_valid = 1. In IDLE both read 0; in COLLECT their values are don't-care.
- Simultaneous i_ins_ready and phase 2 in DONE: the handshake completes and the nibble is ignored. Fetch must re-present it, as guaranteed by o_stall being high on that edge.

## Test plan

- Reset: assert i_reset = 0 mid-COLLECT -> o_ins_valid = 0, o_stall = 0, o_ins_nibbles = 0 immediately. After release, stream 2,5 -> valid, len 2, nibbles 0x52.
- LC: stream 3,2,A,B,C (len 5), i_ins_ready = 1 -> valid on the 5th accept edge, o_ins_nibbles low 20 bits = 0xCBA23, class 3. IDLE next cycle.
- Backpressure: stream 6,1,2,3 with i_ins_ready = 0 for 10 cycles, nibbles still offered on phase 2 -> o_stall = 1, outputs stable. Raise ready -> one transfer, the offered nibbles are not stored.
- Stall inputs: 8,F,1,2,3,4,5 with i_bus_busy high on two decode phases -> len 7, completes two phases later, no duplicated nibble.
- Overflow: MAX_NIBBLES = 7, stream 3,F -> o_error pulses one cycle, state IDLE, o_ins_valid never rises.
- Flush: i_flush during COLLECT of 8,C,1 -> IDLE, no valid. Next stream 0,3 -> clean len-2 instruction.
